// File: rtl/obi_mem_pkg.sv
// Shared types and helpers for the two-port OBI front end of mem_aligned_32.
// Build option OBI_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package obi_mem_pkg;

  typedef logic port_idx_t;

  localparam port_idx_t PORT_IF  = 1'b0;
  localparam port_idx_t PORT_LSU = 1'b1;

  localparam logic [31:0] RDATA_ERR = 32'h0;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_rsp_t;

  // True when every address bit above the word index is zero.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned mem_width);
    logic [31:0] hi;
    hi = addr >> (mem_width + 32'd2);
    return (hi == 32'h0);
  endfunction

endpackage

// File: rtl/obi_mem_arbiter_if.sv
// Bus bundle for obi_mem_arbiter: two OBI manager ports plus the memory port.
// Handshake: a request transfers in the cycle where req_p && gnt_p; its response
// appears exactly one cycle later as rvalid_p, and managers must always accept it.
interface obi_mem_arbiter_if;

  logic        req_0,    req_1;
  logic        gnt_0,    gnt_1;
  logic [31:0] addr_0,   addr_1;
  logic        we_0,     we_1;
  logic [3:0]  be_0,     be_1;
  logic [31:0] wdata_0,  wdata_1;
  logic        rvalid_0, rvalid_1;
  logic [31:0] rdata_0,  rdata_1;
  logic        err_0,    err_1;

  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_err;

  modport slave (
    input  req_0, addr_0, we_0, be_0, wdata_0,
    input  req_1, addr_1, we_1, be_1, wdata_1,
    output gnt_0, rvalid_0, rdata_0, err_0,
    output gnt_1, rvalid_1, rdata_1, err_1,
    output mem_we, mem_be, mem_a, mem_wd,
    input  mem_rd, mem_err
  );

  modport master (
    output req_0, addr_0, we_0, be_0, wdata_0,
    output req_1, addr_1, we_1, be_1, wdata_1,
    input  gnt_0, rvalid_0, rdata_0, err_0,
    input  gnt_1, rvalid_1, rdata_1, err_1,
    input  mem_we, mem_be, mem_a, mem_wd,
    output mem_rd, mem_err
  );

endinterface

// File: rtl/obi_rr_arb2.sv
// Two-input arbiter: round-robin on the last granted port, or fixed priority to
// port 1 when OBI_ARB_FIXED_PRIO_EN is defined. Grants are combinational.
module obi_rr_arb2
  import obi_mem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_0,
  input  logic req_1,
  output logic gnt_0,
  output logic gnt_1,
  output logic gnt_valid
);

  port_idx_t win;

`ifdef OBI_ARB_FIXED_PRIO_EN

  always_comb begin
    win = PORT_IF;
    if (req_1) begin
      win = PORT_LSU;
    end
  end

`else

  port_idx_t last_q, last_d;

  // On a contest the port that did not win last time is served.
  always_comb begin
    win = PORT_IF;
    if (req_0 && req_1) begin
      win = (last_q == PORT_LSU) ? PORT_IF : PORT_LSU;
    end else if (req_1) begin
      win = PORT_LSU;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_valid) begin
      last_d = win;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PORT_LSU;
    end else begin
      last_q <= last_d;
    end
  end

`endif

  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (!reset) begin
      gnt_0 = req_0 && (win == PORT_IF);
      gnt_1 = req_1 && (win == PORT_LSU);
    end
  end

  assign gnt_valid = gnt_0 | gnt_1;

endmodule

// File: rtl/obi_mem_arbiter.sv
// Two-port OBI subordinate in front of mem_aligned_32: arbitration, range check
// and a one-cycle response stage. OBI_ARB_FIXED_PRIO_EN selects fixed priority.
module obi_mem_arbiter
  import obi_mem_pkg::*;
#(
  parameter int unsigned MEM_WIDTH = 6
) (
  input  logic               clk,
  input  logic               reset,
  obi_mem_arbiter_if.slave   bus
);

  obi_req_t  req0_s, req1_s, sel_s;
  logic      gnt_0, gnt_1, gnt_valid;
  logic      sel_in_range;

  logic      rsp_valid_q, rsp_valid_d;
  port_idx_t rsp_port_q,  rsp_port_d;
  obi_rsp_t  rsp_q,       rsp_d;

  always_comb begin
    req0_s.addr  = bus.addr_0;
    req0_s.we    = bus.we_0;
    req0_s.be    = bus.be_0;
    req0_s.wdata = bus.wdata_0;
    req1_s.addr  = bus.addr_1;
    req1_s.we    = bus.we_1;
    req1_s.be    = bus.be_1;
    req1_s.wdata = bus.wdata_1;
  end

  obi_rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_0     (bus.req_0),
    .req_1     (bus.req_1),
    .gnt_0     (gnt_0),
    .gnt_1     (gnt_1),
    .gnt_valid (gnt_valid)
  );

  assign bus.gnt_0 = gnt_0;
  assign bus.gnt_1 = gnt_1;

  // Port 0 drives the memory address lines whenever port 1 is not granted.
  assign sel_s        = gnt_1 ? req1_s : req0_s;
  assign sel_in_range = addr_in_range(sel_s.addr, MEM_WIDTH);

  assign bus.mem_a  = sel_s.addr;
  assign bus.mem_be = sel_s.be;
  assign bus.mem_wd = sel_s.wdata;
  assign bus.mem_we = gnt_valid && sel_s.we && sel_in_range;

  always_comb begin
    rsp_valid_d = gnt_valid;
    rsp_port_d  = rsp_port_q;
    rsp_d       = rsp_q;
    if (gnt_valid) begin
      rsp_port_d = gnt_1 ? PORT_LSU : PORT_IF;
      if (!sel_in_range) begin
        rsp_d.rdata = RDATA_ERR;
        rsp_d.err   = 1'b1;
      end else begin
        rsp_d.rdata = sel_s.we ? 32'h0 : bus.mem_rd;
        rsp_d.err   = bus.mem_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= PORT_IF;
      rsp_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_port_q  <= rsp_port_d;
      rsp_q       <= rsp_d;
    end
  end

  // Masking with reset drops a response whose grant was followed by reset.
  always_comb begin
    bus.rvalid_0 = !reset && rsp_valid_q && (rsp_port_q == PORT_IF);
    bus.rvalid_1 = !reset && rsp_valid_q && (rsp_port_q == PORT_LSU);
    bus.rdata_0  = reset ? 32'h0 : rsp_q.rdata;
    bus.rdata_1  = reset ? 32'h0 : rsp_q.rdata;
    bus.err_0    = reset ? 1'b0  : rsp_q.err;
    bus.err_1    = reset ? 1'b0  : rsp_q.err;
  end

  a_single_gnt : assert property (@(posedge clk) disable iff (reset)
    !(gnt_0 && gnt_1));
  a_gnt_has_req : assert property (@(posedge clk) disable iff (reset)
    (!gnt_0 || bus.req_0) && (!gnt_1 || bus.req_1));

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter: directed scenarios plus randomized traffic scored
// against a transaction-level model of arbitration, memory and responses.
module tb_obi_mem_arbiter;

  logic clk;
  logic reset;
  logic load_en;
  int   checks;
  int   errors;

  logic [31:0] mem_arr [64];
  logic [31:0] ref_mem [64];
  logic        model_last;
  logic [33:0] exp_q [$];

  obi_mem_arbiter_if bus ();

  obi_mem_arbiter #(.MEM_WIDTH(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Word-aligned memory: combinational read, byte-enabled write at the clock edge.
  assign bus.mem_rd  = mem_arr[bus.mem_a[7:2]];
  assign bus.mem_err = ~be_legal(bus.mem_be);

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= ref_mem[i];
    end else if (bus.mem_we && be_legal(bus.mem_be)) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) mem_arr[bus.mem_a[7:2]][8*b +: 8] <= bus.mem_wd[8*b +: 8];
    end
  end

  task automatic drive_port(input int p, input logic req, input logic [31:0] addr,
                            input logic we, input logic [3:0] be, input logic [31:0] wdata);
    if (p == 0) begin
      bus.req_0 = req; bus.addr_0 = addr; bus.we_0 = we; bus.be_0 = be; bus.wdata_0 = wdata;
    end else begin
      bus.req_1 = req; bus.addr_1 = addr; bus.we_1 = we; bus.be_1 = be; bus.wdata_1 = wdata;
    end
  endtask

  task automatic idle();
    drive_port(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drive_port(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem();
    load_en = 1'b1;
    next_cycle();
    load_en = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle();
    repeat (2) next_cycle();
    reset = 1'b0;
    model_last = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_port(0, 1'b1, 32'h14, 1'b0, 4'hF, 32'h0);
    drive_port(1, 1'b1, 32'h8, 1'b1, 4'hF, 32'hA5A5A5A5);
    repeat (2) next_cycle();
    @(negedge clk);
    checks++; if (bus.gnt_0 !== 1'b0) begin errors++; $display("FAIL rst_gnt_0 got %b exp 0", bus.gnt_0); end
    checks++; if (bus.gnt_1 !== 1'b0) begin errors++; $display("FAIL rst_gnt_1 got %b exp 0", bus.gnt_1); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", bus.mem_we); end
    checks++; if ({bus.rvalid_0, bus.rvalid_1} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b%b exp 00", bus.rvalid_0, bus.rvalid_1); end
    checks++; if (bus.rdata_0 !== 32'h0 || bus.err_0 !== 1'b0) begin errors++; $display("FAIL rst_rsp got %h/%b exp 0/0", bus.rdata_0, bus.err_0); end
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    @(negedge clk);
    checks++; if ({bus.rvalid_0, bus.rvalid_1} !== 2'b00) begin errors++; $display("FAIL post_rst_rvalid got %b%b exp 00", bus.rvalid_0, bus.rvalid_1); end
    checks++; if ({bus.rdata_0, bus.err_0, bus.rdata_1, bus.err_1} !== 66'h0) begin errors++; $display("FAIL post_rst_rsp got %h/%b %h/%b exp 0", bus.rdata_0, bus.err_0, bus.rdata_1, bus.err_1); end
    checks++; if ({bus.gnt_0, bus.gnt_1, bus.mem_we} !== 3'b000) begin errors++; $display("FAIL post_rst_gnt got %b%b we %b exp 000", bus.gnt_0, bus.gnt_1, bus.mem_we); end
    next_cycle();
  endtask

  task automatic test_single_read();
    ref_mem[5] = 32'hCAFEF00D;
    load_mem();
    drive_port(0, 1'b1, 32'h14, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    checks++; if ({bus.gnt_0, bus.gnt_1} !== 2'b10) begin errors++; $display("FAIL rd_gnt got %b%b exp 10", bus.gnt_0, bus.gnt_1); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (bus.rvalid_0 !== 1'b1 || bus.rvalid_1 !== 1'b0) begin errors++; $display("FAIL rd_rvalid got %b%b exp 10", bus.rvalid_0, bus.rvalid_1); end
    checks++; if (bus.rdata_0 !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_data got %h exp cafef00d", bus.rdata_0); end
    checks++; if (bus.err_0 !== 1'b0) begin errors++; $display("FAIL rd_err got %b exp 0", bus.err_0); end
    next_cycle();
  endtask

  task automatic test_contest();
    int          exp_g [4];
    logic [31:0] port_data [2];
    logic [31:0] got_data;
    ref_mem[1] = 32'hA0A00001;
    ref_mem[2] = 32'hB1B10002;
    port_data[0] = 32'hA0A00001;
    port_data[1] = 32'hB1B10002;
`ifdef OBI_ARB_FIXED_PRIO_EN
    exp_g[0] = 1; exp_g[1] = 1; exp_g[2] = 1; exp_g[3] = 1;
`else
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`endif
    load_mem();
    apply_reset();
    drive_port(0, 1'b1, 32'h4, 1'b0, 4'hF, 32'h0);
    drive_port(1, 1'b1, 32'h8, 1'b0, 4'hF, 32'h0);
    for (int c = 0; c < 5; c++) begin
      if (c == 4) idle();
      @(negedge clk);
      if (c < 4) begin
        checks++; if (bus.gnt_0 !== (exp_g[c] == 0) || bus.gnt_1 !== (exp_g[c] == 1)) begin errors++; $display("FAIL contest_gnt c%0d got %b%b exp port %0d", c, bus.gnt_0, bus.gnt_1, exp_g[c]); end
      end
      if (c > 0) begin
        got_data = (exp_g[c-1] == 0) ? bus.rdata_0 : bus.rdata_1;
        checks++; if (bus.rvalid_0 !== (exp_g[c-1] == 0) || bus.rvalid_1 !== (exp_g[c-1] == 1)) begin errors++; $display("FAIL contest_rvalid c%0d got %b%b exp port %0d", c, bus.rvalid_0, bus.rvalid_1, exp_g[c-1]); end
        checks++; if (got_data !== port_data[exp_g[c-1]]) begin errors++; $display("FAIL contest_data c%0d got %h exp %h", c, got_data, port_data[exp_g[c-1]]); end
      end
      next_cycle();
    end
  endtask

  task automatic test_write_then_read();
    drive_port(1, 1'b1, 32'h20, 1'b1, 4'hF, 32'h12345678);
    @(negedge clk);
    checks++; if ({bus.gnt_0, bus.gnt_1, bus.mem_we} !== 3'b011) begin errors++; $display("FAIL wr_gnt got %b%b we %b exp 01 we 1", bus.gnt_0, bus.gnt_1, bus.mem_we); end
    next_cycle();
    drive_port(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    drive_port(0, 1'b1, 32'h20, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    checks++; if (bus.gnt_0 !== 1'b1) begin errors++; $display("FAIL wr_rd_gnt got %b exp 1", bus.gnt_0); end
    checks++; if ({bus.rvalid_1, bus.err_1} !== 2'b10 || bus.rdata_1 !== 32'h0) begin errors++; $display("FAIL wr_rsp got v%b e%b %h exp v1 e0 0", bus.rvalid_1, bus.err_1, bus.rdata_1); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (bus.rvalid_0 !== 1'b1 || bus.rdata_0 !== 32'h12345678) begin errors++; $display("FAIL raw_data got v%b %h exp v1 12345678", bus.rvalid_0, bus.rdata_0); end
    next_cycle();
    ref_mem[8] = 32'h12345678;
  endtask

  task automatic test_out_of_range();
    ref_mem[0] = 32'h11111111;
    load_mem();
    drive_port(1, 1'b1, 32'h100, 1'b1, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if ({bus.gnt_1, bus.mem_we} !== 2'b10) begin errors++; $display("FAIL oor_gnt got %b we %b exp 1 we 0", bus.gnt_1, bus.mem_we); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if ({bus.rvalid_1, bus.err_1} !== 2'b11 || bus.rdata_1 !== 32'h0) begin errors++; $display("FAIL oor_rsp got v%b e%b %h exp v1 e1 0", bus.rvalid_1, bus.err_1, bus.rdata_1); end
    checks++; if (mem_arr[0] !== 32'h11111111) begin errors++; $display("FAIL oor_array got %h exp 11111111", mem_arr[0]); end
    next_cycle();
  endtask

  task automatic test_illegal_be();
    drive_port(0, 1'b1, 32'h14, 1'b0, 4'b0110, 32'h0);
    @(negedge clk);
    checks++; if (bus.gnt_0 !== 1'b1) begin errors++; $display("FAIL be_gnt got %b exp 1", bus.gnt_0); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if ({bus.rvalid_0, bus.err_0} !== 2'b11) begin errors++; $display("FAIL be_err got v%b e%b exp v1 e1", bus.rvalid_0, bus.err_0); end
    checks++; if (bus.rdata_0 !== 32'hCAFEF00D) begin errors++; $display("FAIL be_data got %h exp cafef00d", bus.rdata_0); end
    next_cycle();
  endtask

  task automatic test_reset_discard();
    drive_port(0, 1'b1, 32'h14, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    checks++; if (bus.gnt_0 !== 1'b1) begin errors++; $display("FAIL disc_gnt got %b exp 1", bus.gnt_0); end
    @(posedge clk); #1;
    reset = 1'b1;
    idle();
    @(negedge clk);
    checks++; if ({bus.rvalid_0, bus.rvalid_1} !== 2'b00) begin errors++; $display("FAIL disc_rvalid got %b%b exp 00", bus.rvalid_0, bus.rvalid_1); end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({bus.rvalid_0, bus.rvalid_1} !== 2'b00) begin errors++; $display("FAIL disc_after got %b%b exp 00", bus.rvalid_0, bus.rvalid_1); end
    next_cycle();
    model_last = 1'b1;
  endtask

  task automatic test_random(input int n);
    logic [3:0]  legal_list [7];
    logic        r [2];
    logic        w [2];
    logic [3:0]  be [2];
    logic [31:0] a [2];
    logic [31:0] wd [2];
    logic [33:0] e;
    logic        granted, win, in_rng;
    logic [5:0]  idx;
    logic [31:0] rd, got_d;
    logic        got_e;
    int          bad;
    legal_list[0] = 4'b0001; legal_list[1] = 4'b0010; legal_list[2] = 4'b0100;
    legal_list[3] = 4'b1000; legal_list[4] = 4'b0011; legal_list[5] = 4'b1100;
    legal_list[6] = 4'b1111;
    load_mem();
    apply_reset();
    for (int c = 0; c <= n; c++) begin
      for (int p = 0; p < 2; p++) begin
        r[p]  = (c < n) && ($urandom_range(0, 3) != 0);
        w[p]  = $urandom_range(0, 1) == 1;
        be[p] = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_list[$urandom_range(0, 6)];
        a[p]  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(0, 63)) * 32'd4;
        wd[p] = $urandom;
        drive_port(p, r[p], a[p], w[p], be[p], wd[p]);
      end
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got_d = e[33] ? bus.rdata_1 : bus.rdata_0;
        got_e = e[33] ? bus.err_1 : bus.err_0;
        checks++; if (bus.rvalid_0 !== !e[33] || bus.rvalid_1 !== e[33]) begin errors++; $display("FAIL rnd_rvalid c%0d got %b%b exp port %0d", c, bus.rvalid_0, bus.rvalid_1, e[33]); end
        checks++; if (got_d !== e[31:0] || got_e !== e[32]) begin errors++; $display("FAIL rnd_rsp c%0d got %h/%b exp %h/%b", c, got_d, got_e, e[31:0], e[32]); end
      end else begin
        checks++; if ({bus.rvalid_0, bus.rvalid_1} !== 2'b00) begin errors++; $display("FAIL rnd_idle c%0d got %b%b exp 00", c, bus.rvalid_0, bus.rvalid_1); end
      end
      granted = r[0] || r[1];
`ifdef OBI_ARB_FIXED_PRIO_EN
      win = r[1];
`else
      win = (r[0] && r[1]) ? !model_last : r[1];
`endif
      in_rng = (a[win] < 32'd256);
      checks++; if (bus.gnt_0 !== (granted && !win) || bus.gnt_1 !== (granted && win)) begin errors++; $display("FAIL rnd_gnt c%0d got %b%b exp req %b%b win %0d", c, bus.gnt_0, bus.gnt_1, r[0], r[1], win); end
      checks++; if (bus.mem_we !== (granted && w[win] && in_rng)) begin errors++; $display("FAIL rnd_we c%0d got %b exp %b", c, bus.mem_we, granted && w[win] && in_rng); end
      if (granted) begin
        idx = a[win][7:2];
        rd  = ref_mem[idx];
        if (!in_rng)     exp_q.push_back({win, 1'b1, 32'h0});
        else if (w[win]) exp_q.push_back({win, !be_legal(be[win]), 32'h0});
        else             exp_q.push_back({win, !be_legal(be[win]), rd});
        if (in_rng && w[win] && be_legal(be[win]))
          for (int b = 0; b < 4; b++)
            if (be[win][b]) ref_mem[idx][8*b +: 8] = wd[win][8*b +: 8];
        model_last = win;
      end
      next_cycle();
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem_arr[i] !== ref_mem[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rnd_mem_image got %0d differing words exp 0", bad); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    load_en = 1'b0;
    model_last = 1'b1;
    idle();
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    load_mem();
    test_reset();
    test_single_read();
    test_contest();
    test_write_then_read();
    test_out_of_range();
    test_illegal_be();
    test_reset_discard();
    test_random(400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obi_mem_arbiter.md
# obi_mem_arbiter

Two-port OBI subordinate front end for the shared word-aligned data/instruction memory (`mem_aligned_32`). It arbitrates between an instruction-fetch manager (port 0) and a load/store manager (port 1) and drives the single memory port. It registers the read data and error into a one-cycle OBI response stage and rejects out-of-range addresses before they reach the array. It sits between the core's two OBI managers and the memory instance.

## Interface
Parameters:
- `MEM_WIDTH`, 6: log2 of memory depth in words; must match the memory instance.

Ports (`p` = 0, 1; each listed signal exists per port as `*_0` / `*_1`):
- Clocking and reset: one clock; reset is synchronous and active-high.
  - `clk` input 1: clock; all state updates on the rising edge.
  - `reset` input 1: synchronous, active-high reset.
- OBI request channel:
  - `req_p` input 1: OBI request.
  - `gnt_p` output 1: OBI grant (combinational).
  - `addr_p` input 32: byte address.
  - `we_p` input 1: write enable.
  - `be_p` input 4: byte enable.
  - `wdata_p` input 32: write data.
- OBI response channel:
  - `rvalid_p` output 1: response valid.
  - `rdata_p` output 32: response read data.
  - `err_p` output 1: response error.
- Memory side:
  - `mem_we` output 1: memory write enable.
  - `mem_be` output 4: memory byte enable.
  - `mem_a` output 32: memory address.
  - `mem_wd` output 32: memory write data.
  - `mem_rd` input 32: combinational read data from memory.
  - `mem_err` input 1: memory illegal-`be` flag.

## Operation
- Arbitration is combinational in the request cycle.
  - At most one `gnt_p` is high per cycle.
  - `gnt_p` is high only if `req_p` is high.
  - A single requester is always granted; the memory accepts one access per cycle.
- Round-robin register `last`: on a contested cycle, the port not equal to `last` wins. `last` updates to the granted port on every grant.
- Memory mux:
  - `mem_a`, `mem_be`, `mem_wd` follow the granted port.
  - With no grant they follow port 0 and `mem_we` = 0.
- Range check: an address is out of range when `addr[31:MEM_WIDTH+2]` is nonzero.
  - An out-of-range request is still granted.
  - `mem_we` is forced to 0 for it.
  - Its response has `err` = 1 and `rdata` = 0.
- In-range responses:
  - Reads: `rdata` = `mem_rd` captured at the end of the grant cycle.
  - Writes: `rdata` = 0.
  - `err` = `mem_err` captured at the end of the grant cycle.
- Response stage registers:
  - `rsp_valid`, `rsp_port`, `rsp_data`, `rsp_err`.
  - `rvalid_p` = `rsp_valid && rsp_port == p`.
  - `rdata_p` and `err_p` are driven from the shared registers; they are only meaningful while `rvalid_p` is high.
- No `rready`: managers must always accept responses.
- Back-to-back grants are allowed, to the same or alternating ports. The stage refills every cycle, so there is no stall.

## Timing
- Grant in cycle N leads to `rvalid` in cycle N+1 on the same port. Latency is exactly 1 and there is one response per grant.
- A write granted in cycle N is committed at the end of N. A read granted in N+1 to the same address (from either port) returns the new data.
- Reset values, while `reset` is high and on the first cycle after:
  - `gnt_p` = 0; all `rvalid_p` = 0; `rdata_p` = 0; `err_p` = 0; `mem_we` = 0.
  - `last` = 1, so port 0 wins the first contest.
- Reset in the cycle after a grant discards that grant's response; no `rvalid` is ever produced for it.
- If `req_p` is dropped without a grant, no state changes.

## Configuration
- `OBI_ARB_FIXED_PRIO_EN`:
  - Defined: port 1 (load/store) always wins a contest; `last` is not implemented.
  - Undefined: round-robin as above.
- Nothing else changes between the two builds.

## Structure
- Package `obi_mem_pkg`:
  - `obi_req_t` struct: `addr`, `we`, `be`, `wdata`.
  - `obi_rsp_t` struct: `rdata`, `err`.
  - Port index type.
  - Error read value `RDATA_ERR` = 32'h0.
- Sub-module `obi_rr_arb2`: two-input round-robin arbiter holding `last`. With `OBI_ARB_FIXED_PRIO_EN` it becomes a fixed-priority compare.

## Test plan
- Single read: preload word 5 = 32'hCAFEF00D; port 0 reads `addr` 0x14, `be` 4'b1111.
  - Expect `gnt_0` in the same cycle.
  - Next cycle: `rvalid_0` = 1, `rdata_0` = 32'hCAFEF00D, `err_0` = 0; `rvalid_1` = 0.
- Contest, round-robin:
  - Both ports request every cycle for 4 cycles after reset.
  - Expect grants 0, 1, 0, 1, with responses on the matching port one cycle later.
- Contest, fixed priority: same stimulus with `OBI_ARB_FIXED_PRIO_EN` defined. Expect port 1 granted for all 4 cycles.
- Write then read:
  - Port 1 writes 32'h12345678 to 0x20 in cycle N; port 0 reads 0x20 in N+1.
  - Expect `rdata_0` = 32'h12345678 in N+2.
- Out of range: port 1 writes `addr` 0x100 with `MEM_WIDTH` = 6.
  - Expect `mem_we` = 0 and array unchanged.
  - Next cycle: `err_1` = 1, `rdata_1` = 0.
- Illegal `be` and reset:
  - Read with `be` 4'b0110: expect `err_0` = 1 next cycle.
  - Assert `reset` in the cycle after a grant: expect no `rvalid`.
